// File: rtl/cve2_trace_buffer.sv
// rtl/cve2_trace_buffer.sv - RVFI retirement trace buffer with STREAM, WRAP and TRIGGER capture.
// Records are stored unreset; out_* is a first-word fall-through view of the head entry.
module cve2_trace_buffer #(
  parameter int Depth       = 16,
  parameter int PostTrigger = 8,
  parameter int DropCntW    = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               mode_i,
  input  logic                     arm_i,
  input  logic                     stop_i,
  input  logic [31:0]              trig_pc_i,
  input  logic                     rvfi_valid,
  input  logic [63:0]              rvfi_order,
  input  logic [31:0]              rvfi_insn,
  input  logic                     rvfi_trap,
  input  logic [31:0]              rvfi_pc_rdata,
  input  logic [4:0]               rvfi_rd_addr,
  input  logic [31:0]              rvfi_rd_wdata,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [63:0]              out_order_o,
  output logic [31:0]              out_insn_o,
  output logic                     out_trap_o,
  output logic [31:0]              out_pc_o,
  output logic [4:0]               out_rd_addr_o,
  output logic [31:0]              out_rd_wdata_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic [DropCntW-1:0]      drop_cnt_o,
  output logic [1:0]               state_o,
  output logic                     triggered_o
);

  localparam int AW = $clog2(Depth);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_POST   = 2'd2,
    S_FROZEN = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_mode;
  logic [31:0]         r_trig_pc;
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [LW-1:0]       r_level;
  logic [DropCntW-1:0] r_drop;
  logic [AW-1:0]       r_post;
  logic                r_triggered;

  logic [63:0] r_mem_order [Depth];
  logic [31:0] r_mem_insn  [Depth];
  logic        r_mem_trap  [Depth];
  logic [31:0] r_mem_pc    [Depth];
  logic [4:0]  r_mem_rd    [Depth];
  logic [31:0] r_mem_wdata [Depth];

  logic w_stream;
  logic w_trig_mode;
  logic w_full;
  logic w_cap;
  logic w_out_valid;
  logic w_pop;
  logic w_hit;
  logic w_arm;
  logic w_drop;
  logic w_push;
  logic w_ovw;

  // Reserved mode 3 behaves as STREAM.
  assign w_stream    = (r_mode != 2'd1) && (r_mode != 2'd2);
  assign w_trig_mode = (r_mode == 2'd2);
  assign w_full      = (r_level == LW'(Depth));
  assign w_cap       = rvfi_valid && ((r_state == S_ARMED) || (r_state == S_POST));
  assign w_out_valid = (w_stream || (r_state == S_FROZEN)) && (r_level != '0);
  assign w_pop       = w_out_valid && out_ready_i;
  assign w_hit       = w_trig_mode && (r_state == S_ARMED) && w_cap && (rvfi_pc_rdata == r_trig_pc);
  assign w_arm       = (r_state == S_IDLE) && arm_i;
  assign w_drop      = w_cap && w_stream && w_full && !w_pop;
  assign w_push      = w_cap && !w_drop;
  // WRAP/TRIGGER never drain while capturing, so an overwrite never coincides with a pop.
  assign w_ovw       = w_push && !w_stream && w_full;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (arm_i) w_next = S_ARMED;
      end
      S_ARMED: begin
        if (stop_i)     w_next = S_FROZEN;
        else if (w_hit) w_next = S_POST;
      end
      S_POST: begin
        if (stop_i)                          w_next = S_FROZEN;
        else if (r_post == '0)               w_next = S_FROZEN;
        else if (w_cap && (r_post == AW'(1))) w_next = S_FROZEN;
      end
      S_FROZEN: begin
        if ((r_level == '0) || (w_pop && (r_level == LW'(1)))) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    state_o     = r_state;
    out_valid_o = w_out_valid;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_drop      <= '0;
      r_post      <= '0;
      r_triggered <= 1'b0;
      r_mode      <= 2'd0;
      r_trig_pc   <= '0;
    end else if (w_arm) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_drop      <= '0;
      r_post      <= '0;
      r_triggered <= 1'b0;
      r_mode      <= mode_i;
      r_trig_pc   <= trig_pc_i;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop || w_ovw) r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_ovw && !w_pop) r_level <= r_level + LW'(1);
      else if (!w_push && w_pop)      r_level <= r_level - LW'(1);
      if (w_drop && (r_drop != {DropCntW{1'b1}})) r_drop <= r_drop + DropCntW'(1);
      if (w_hit) begin
        r_triggered <= 1'b1;
        r_post      <= AW'(PostTrigger);
      end else if ((r_state == S_POST) && w_cap && (r_post != '0)) begin
        r_post <= r_post - AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem_order[r_wptr] <= rvfi_order;
      r_mem_insn[r_wptr]  <= rvfi_insn;
      r_mem_trap[r_wptr]  <= rvfi_trap;
      r_mem_pc[r_wptr]    <= rvfi_pc_rdata;
      r_mem_rd[r_wptr]    <= rvfi_rd_addr;
      r_mem_wdata[r_wptr] <= rvfi_rd_wdata;
    end
  end

  assign out_order_o    = r_mem_order[r_rptr];
  assign out_insn_o     = r_mem_insn[r_rptr];
  assign out_trap_o     = r_mem_trap[r_rptr];
  assign out_pc_o       = r_mem_pc[r_rptr];
  assign out_rd_addr_o  = r_mem_rd[r_rptr];
  assign out_rd_wdata_o = r_mem_wdata[r_rptr];
  assign level_o        = r_level;
  assign drop_cnt_o     = r_drop;
  assign triggered_o    = r_triggered;

endmodule
